// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared constants, address type and index validity helper for the register file.
package reg_file_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int NUM_REGS_DEF = 32;
  localparam int ZERO_REG = 0;
  typedef logic [$clog2(NUM_REGS_DEF)-1:0] reg_addr_t;
  function automatic logic valid_idx(input int idx, input int n);
    return idx != ZERO_REG && idx < n;
  endfunction
endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register busy bits; a same-cycle issue overrides a write-back clear.
module reg_scoreboard import reg_file_pkg::*; #(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  output logic              a_busy,
  output logic              b_busy
);
  logic [NUM_REGS-1:0] busy;
  always_ff @(posedge clk or posedge rst)
    if (rst) busy <= '0;
    else
      for (int i = 1; i < NUM_REGS; i++)
        if (set && int'(set_addr) == i) busy[i] <= 1'b1;
        else if (clr && int'(clr_addr) == i) busy[i] <= 1'b0;
  assign a_busy = valid_idx(int'(addr_a), NUM_REGS) && busy[addr_a];
  assign b_busy = valid_idx(int'(addr_b), NUM_REGS) && busy[addr_b];
endmodule

// File: rtl/reg_file.sv
// reg_file: 2-read/1-write register file with r0 hardwired to zero and a RAW busy scoreboard.
// Define REG_FILE_BYPASS_EN to forward same-cycle write-back data to the read ports.
module reg_file import reg_file_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic              a_busy,
  output logic              b_busy,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr_d,
  input  logic [DATA_W-1:0] data,
  input  logic              issue,
  input  logic [ADDR_W-1:0] issue_addr
);
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic ok_a, ok_b, sb_a_busy, sb_b_busy;
  assign ok_a = valid_idx(int'(addr_a), NUM_REGS);
  assign ok_b = valid_idx(int'(addr_b), NUM_REGS);
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    else if (write && valid_idx(int'(addr_d), NUM_REGS)) regs[addr_d] <= data;
  reg_scoreboard #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_sb (
    .clk(clk), .rst(rst),
    .set(issue), .set_addr(issue_addr),
    .clr(write), .clr_addr(addr_d),
    .addr_a(addr_a), .addr_b(addr_b),
    .a_busy(sb_a_busy), .b_busy(sb_b_busy)
  );
`ifdef REG_FILE_BYPASS_EN
  logic hit_a, hit_b;
  assign hit_a = !rst && write && ok_a && addr_d == addr_a;
  assign hit_b = !rst && write && ok_b && addr_d == addr_b;
  assign a = hit_a ? data : ok_a ? regs[addr_a] : '0;
  assign b = hit_b ? data : ok_b ? regs[addr_b] : '0;
  // a same-cycle issue to the forwarded register keeps it busy
  assign a_busy = hit_a ? issue && issue_addr == addr_a : sb_a_busy;
  assign b_busy = hit_b ? issue && issue_addr == addr_b : sb_b_busy;
`else
  assign a = ok_a ? regs[addr_a] : '0;
  assign b = ok_b ? regs[addr_b] : '0;
  assign a_busy = sb_a_busy;
  assign b_busy = sb_b_busy;
`endif
endmodule
